// File: rtl/cnn_layer_sequencer_if.sv
// cnn_layer_sequencer_if: command, weight-beat and stage-control bundle between host/controllers and the sequencer.
interface cnn_layer_sequencer_if #(parameter int MAX_FILTERS = 32);
    logic                   start_i;
    logic [13:0]            op_code_i;
    logic                   w_valid_i;
    logic                   w_ready_o;
    logic                   pu_finish_i;
    logic                   conv_finish_i;
    logic                   pool_finish_i;
    logic                   fc_finish_i;
    logic                   pu_en_o;
    logic                   conv_en_o;
    logic                   pool_en_o;
    logic                   fc_en_o;
    logic [MAX_FILTERS-1:0] weight_en_o;
    logic [4:0]             weight_dim_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   err_o;
    modport master (
        output start_i, op_code_i, w_valid_i, pu_finish_i, conv_finish_i, pool_finish_i, fc_finish_i,
        input  w_ready_o, pu_en_o, conv_en_o, pool_en_o, fc_en_o, weight_en_o, weight_dim_o, busy_o, done_o, err_o
    );
    modport slave (
        input  start_i, op_code_i, w_valid_i, pu_finish_i, conv_finish_i, pool_finish_i, fc_finish_i,
        output w_ready_o, pu_en_o, conv_en_o, pool_en_o, fc_en_o, weight_en_o, weight_dim_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: latches one layer opcode, streams K*K weights per filter, primes the PU,
// then drives conv / conv+pool / conv+pool+FC until the stage controllers report completion.
module cnn_layer_sequencer #(
    parameter int MAX_FILTERS = 32,
    parameter int IMG_W       = 32,
    parameter int BEAT_ELEMS  = 2,
    parameter int CNT_W       = 16
) (
    input logic clk,
    input logic rst,
    cnn_layer_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD_W, FILL, RUN, FC, DONE} state_t;
    localparam logic [2:0] M_NOP = 3'b000, M_CONV = 3'b001, M_CP = 3'b010;
    localparam logic [2:0] M_FCO = 3'b011, M_CPF = 3'b110;
    localparam logic [6:0] MAXF = 7'(MAX_FILTERS);
    localparam logic [CNT_W-1:0] POOL_LAT = CNT_W'(IMG_W + 2);
    state_t state, state_n;
    logic [2:0] mode, op_m;
    logic [5:0] nf, fi, op_f;
    logic [4:0] kd, op_k;
    logic [9:0] beat, kk, bpf;
    logic [CNT_W-1:0] cnt, fill_lat;
    logic pu_seen, conv_seen, err;
    logic op_conv, op_bad, accept, last_beat, pool_mode;
    assign op_m      = bus.op_code_i[2:0];
    assign op_f      = bus.op_code_i[8:3];
    assign op_k      = bus.op_code_i[13:9];
    assign op_conv   = op_m == M_CONV || op_m == M_CP || op_m == M_CPF;
    assign op_bad    = op_m[2:1] == 2'b10 || (op_conv && (op_f == 6'd0 || {1'b0, op_f} > MAXF || op_k == 5'd0));
    assign accept    = state == IDLE && bus.start_i && op_m != M_NOP && !op_bad;
    assign kk        = 10'(kd) * 10'(kd);
    assign bpf       = 10'((kk + 10'(BEAT_ELEMS - 1)) / 10'(BEAT_ELEMS));
    assign last_beat = beat == bpf - 10'd1;
    assign fill_lat  = (CNT_W'(kd) - CNT_W'(1)) * CNT_W'(IMG_W) + CNT_W'(kd);
    assign pool_mode = mode == M_CP || mode == M_CPF;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = op_conv ? LOAD_W : (op_m == M_FCO ? FC : DONE);
            LOAD_W:  if (bus.w_valid_i && last_beat && fi == nf - 6'd1) state_n = FILL;
            FILL:    if (cnt == fill_lat - CNT_W'(1)) state_n = RUN;
            RUN:     if (pool_mode ? bus.pool_finish_i : bus.conv_finish_i) state_n = mode == M_CPF ? FC : DONE;
            FC:      if (bus.fc_finish_i) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // weight_en is the only output allowed to follow w_valid combinationally
    assign bus.weight_en_o  = (state == LOAD_W && bus.w_valid_i) ? MAX_FILTERS'(1) << fi : '0;
    assign bus.w_ready_o    = state == LOAD_W;
    assign bus.pu_en_o      = state == FILL || (state == RUN && !pu_seen);
    assign bus.conv_en_o    = state == RUN && !(pool_mode && conv_seen);
    assign bus.pool_en_o    = state == RUN && pool_mode && cnt == POOL_LAT;
    assign bus.fc_en_o      = state == FC;
    assign bus.busy_o       = state != IDLE;
    assign bus.done_o       = state == DONE;
    assign bus.err_o        = err;
    assign bus.weight_dim_o = kd;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode      <= '0;
            nf        <= '0;
            kd        <= '0;
            fi        <= '0;
            beat      <= '0;
            cnt       <= '0;
            pu_seen   <= 1'b0;
            conv_seen <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            err   <= state == IDLE && bus.start_i && op_bad;
            if (accept) begin
                mode <= op_m;
                nf   <= op_f;
                kd   <= op_k;
            end
            if (state == LOAD_W && bus.w_valid_i) begin
                beat <= last_beat ? '0 : beat + 10'd1;
                fi   <= fi + 6'(last_beat);
            end
            // the counter restarts at RUN entry and saturates at the pooling latency
            if (state == FILL) cnt <= state_n == RUN ? '0 : cnt + CNT_W'(1);
            else if (state == RUN && cnt != POOL_LAT) cnt <= cnt + CNT_W'(1);
            if (state == RUN && bus.pu_finish_i) pu_seen <= 1'b1;
            if (state == RUN && bus.conv_finish_i) conv_seen <= 1'b1;
            if (state == DONE) begin
                fi        <= '0;
                beat      <= '0;
                cnt       <= '0;
                pu_seen   <= 1'b0;
                conv_seen <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: directed scenarios with a weight-enable scoreboard for cnn_layer_sequencer.
module tb_cnn_layer_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    cnn_layer_sequencer_if #(.MAX_FILTERS(32)) bus();
    cnn_layer_sequencer #(.MAX_FILTERS(32), .IMG_W(32), .BEAT_ELEMS(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] op(input int k, input int f, input logic [2:0] m);
        return {5'(k), 6'(f), m};
    endfunction

    task automatic start_cmd(input logic [13:0] o);
        bus.op_code_i = o;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    // drives beats until nf*ceil(k*k/2) are accepted; scoreboard holds the expected one-hot enable
    task automatic load_w(input int nf, input int k, input bit toggle, output int cycles);
        int bpf, beats, f, b;
        bpf = (k * k + 1) / 2;
        beats = 0; f = 0; b = 0; cycles = 0;
        while (beats < nf * bpf && cycles < 400) begin
            bus.w_valid_i = toggle ? cycles[0] : 1'b1;
            exp_q.push_back(bus.w_valid_i ? (32'd1 << f) : 32'd0);
            #1;
            chk("w_ready", bus.w_ready_o, 1);
            chk("weight_en", bus.weight_en_o, exp_q.pop_front());
            if (bus.w_valid_i) begin
                beats++;
                if (b == bpf - 1) begin b = 0; f++; end else b++;
            end
            tick();
            cycles++;
        end
        bus.w_valid_i = 1'b0;
        chk("load_beats", beats, nf * bpf);
    endtask

    task automatic wait_fill(output int n);
        n = 0;
        while (bus.pu_en_o && !bus.conv_en_o && n < 1000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int cyc, n;
        bus.start_i = 0; bus.op_code_i = '0; bus.w_valid_i = 0;
        bus.pu_finish_i = 0; bus.conv_finish_i = 0; bus.pool_finish_i = 0; bus.fc_finish_i = 0;
        tick(); tick();
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_enables", {bus.pu_en_o, bus.conv_en_o, bus.pool_en_o, bus.fc_en_o, bus.w_ready_o}, 0);
        chk("rst_flags", {bus.done_o, bus.err_o, bus.weight_dim_o}, 0);
        rst = 1'b0;
        tick();
        // CONV F=2 K=3, continuous beats
        start_cmd(op(3, 2, 3'b001));
        chk("c1_busy", bus.busy_o, 1);
        chk("c1_dim", bus.weight_dim_o, 3);
        load_w(2, 3, 1'b0, cyc);
        chk("c1_load_cycles", cyc, 10);
        wait_fill(n);
        chk("c1_fill_len", n, 67);
        chk("c1_run", {bus.conv_en_o, bus.pu_en_o, bus.pool_en_o}, 3'b110);
        start_cmd(op(0, 0, 3'b111));
        chk("c1_start_ignored", {bus.conv_en_o, bus.done_o, bus.busy_o}, 3'b101);
        bus.pu_finish_i = 1; tick(); bus.pu_finish_i = 0;
        chk("c1_pu_drop", {bus.pu_en_o, bus.conv_en_o}, 2'b01);
        bus.conv_finish_i = 1; tick(); bus.conv_finish_i = 0;
        chk("c1_done", {bus.done_o, bus.busy_o, bus.conv_en_o}, 3'b110);
        tick();
        chk("c1_idle", {bus.done_o, bus.busy_o}, 0);
        // same op, toggling valid, stray pu_finish during load
        start_cmd(op(3, 2, 3'b001));
        bus.pu_finish_i = 1;
        load_w(2, 3, 1'b1, cyc);
        bus.pu_finish_i = 0;
        chk("c2_load_cycles", cyc, 20);
        wait_fill(n);
        chk("c2_fill_len", n, 67);
        chk("c2_pu_kept", {bus.pu_en_o, bus.conv_en_o}, 2'b11);
        bus.conv_finish_i = 1; tick(); bus.conv_finish_i = 0;
        chk("c2_done", bus.done_o, 1);
        tick();
        // CONV_POOL_FC F=1 K=5
        start_cmd(op(5, 1, 3'b110));
        load_w(1, 5, 1'b0, cyc);
        chk("c3_load_cycles", cyc, 13);
        wait_fill(n);
        chk("c3_fill_len", n, 133);
        n = 0;
        while (!bus.pool_en_o && n < 100) begin
            bus.conv_finish_i = (n == 10);
            tick();
            n++;
        end
        bus.conv_finish_i = 0;
        chk("c3_pool_lat", n, 34);
        chk("c3_conv_drop", {bus.conv_en_o, bus.pool_en_o, bus.pu_en_o}, 3'b011);
        bus.pool_finish_i = 1; bus.fc_finish_i = 1; tick();
        bus.pool_finish_i = 0; bus.fc_finish_i = 0;
        chk("c3_fc", {bus.fc_en_o, bus.done_o, bus.pool_en_o}, 3'b100);
        tick(); tick();
        chk("c3_fc_wait", {bus.fc_en_o, bus.done_o}, 2'b10);
        bus.fc_finish_i = 1; tick(); bus.fc_finish_i = 0;
        chk("c3_done", {bus.done_o, bus.fc_en_o}, 2'b10);
        tick();
        chk("c3_idle", bus.busy_o, 0);
        // rejected commands
        start_cmd(op(3, 1, 3'b101));
        chk("e1_err", {bus.err_o, bus.busy_o, bus.w_ready_o}, 3'b100);
        tick();
        chk("e1_clear", bus.err_o, 0);
        start_cmd(op(3, 33, 3'b001));
        chk("e2_err", {bus.err_o, bus.busy_o, bus.weight_en_o}, {2'b10, 32'd0});
        tick();
        start_cmd(op(0, 1, 3'b010));
        chk("e3_err", {bus.err_o, bus.busy_o}, 2'b10);
        start_cmd(op(3, 1, 3'b000));
        chk("nop", {bus.err_o, bus.busy_o}, 0);
        // reset mid-FILL, then reload from filter 0
        start_cmd(op(3, 2, 3'b001));
        load_w(2, 3, 1'b0, cyc);
        tick(); tick();
        chk("r_in_fill", bus.pu_en_o, 1);
        rst = 1; tick(); rst = 0;
        chk("r_abort", {bus.pu_en_o, bus.busy_o, bus.weight_dim_o}, 0);
        start_cmd(op(3, 2, 3'b001));
        load_w(2, 3, 1'b0, cyc);
        chk("r_reload_cycles", cyc, 10);
        rst = 1; tick(); rst = 0;
        // FLUSH and FC_ONLY
        start_cmd(op(0, 0, 3'b111));
        chk("fl_done", {bus.busy_o, bus.done_o}, 2'b11);
        tick();
        chk("fl_idle", {bus.busy_o, bus.done_o}, 0);
        start_cmd(op(0, 0, 3'b011));
        chk("fco_fc", {bus.fc_en_o, bus.conv_en_o, bus.w_ready_o}, 3'b100);
        bus.fc_finish_i = 1; tick(); bus.fc_finish_i = 0;
        chk("fco_done", bus.done_o, 1);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
